// File: rtl/hack_pkg.sv
// Shared types for the Hack fetch path.
// Word type, fetch FSM states and the default reset PC.
package hack_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam word_t RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/pc16.sv
// 16-bit program counter: reset > load > increment.
// nxt exposes the value q takes at the coming edge.
module pc16
    import hack_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  inc,
    input  word_t d,
    output word_t q,
    output word_t nxt
);

    always_comb begin
        nxt = q;
        priority case (1'b1)
            load:    nxt = d;
            inc:     nxt = q + 16'd1;
            default: nxt = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_PC;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/pc16_fetch.sv
// Hack instruction fetch: IDLE/REQ/HOLD FSM over a ROM
// request/ack port with a valid/ready instruction output.
module pc16_fetch
    import hack_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        jump_valid,
    input  logic [15:0] jump_addr,
    output logic        rom_req,
    output logic [15:0] rom_addr,
    input  logic        rom_ack,
    input  logic [15:0] rom_data,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    fetch_state_e state;
    fetch_state_e state_nxt;
    logic         discard;
    logic         discard_nxt;
    logic         pc_inc;
    logic         capture;
    word_t        pc;
    word_t        pc_nxt;

    pc16 #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk  (clk),
        .rst_n(rst_n),
        .load (jump_valid),
        .inc  (pc_inc),
        .d    (jump_addr),
        .q    (pc),
        .nxt  (pc_nxt)
    );

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        pc_inc      = 1'b0;
        capture     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (rom_ack) begin
                    // Stale data after a jump: re-issue at pc
                    if (jump_valid || discard) begin
                        discard_nxt = 1'b0;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end else if (jump_valid) begin
                    discard_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (jump_valid) begin
                    state_nxt = ST_REQ;
                end else if (instr_ready) begin
                    pc_inc    = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            discard <= 1'b0;
        end else begin
            state   <= state_nxt;
            discard <= discard_nxt;
        end
    end

    // Address is frozen while a request waits for its ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= RESET_PC;
        end else if (!(state == ST_REQ && !rom_ack)) begin
            rom_addr <= pc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= 16'h0000;
            instr_pc <= 16'h0000;
        end else if (capture) begin
            instr    <= rom_data;
            instr_pc <= rom_addr;
        end
    end

    assign rom_req     = (state == ST_REQ);
    assign instr_valid = (state == ST_HOLD);

endmodule

// File: doc/pc16_fetch.md
PC16_FETCH -- requirements
Module: pc16_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the fetch address loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 en  input  1  SHALL permit leaving IDLE; low in IDLE holds the block idle.
REQ-005 jump_valid  input  1  SHALL request a PC load (Hack PC "load") this cycle.
REQ-006 jump_addr  input  16  SHALL be the jump target (driven from the upstream mux16 output).
REQ-007 rom_req  output  1  SHALL request the ROM word at rom_addr.
REQ-008 rom_addr  output  16  SHALL carry the address of the outstanding request.
REQ-009 rom_ack  input  1  SHALL mark rom_data valid in any cycle with rom_req=1.
REQ-010 rom_data  input  16  SHALL be the returned instruction word.
REQ-011 instr  output  16  SHALL be the fetched instruction presented downstream.
REQ-012 instr_pc  output  16  SHALL be the address instr was fetched from.
REQ-013 instr_valid  output  1  SHALL flag instr/instr_pc valid.
REQ-014 instr_ready  input  1  SHALL accept instr when high with instr_valid (transfer).

Function
REQ-015 States SHALL be IDLE, REQ, HOLD; reset state IDLE.
REQ-016 IDLE -> REQ when en=1; rom_req=0, instr_valid=0 in IDLE.
REQ-017 REQ: rom_req=1, rom_addr=pc held stable until rom_ack; rom_ack=0 stays in REQ.
REQ-018 REQ with rom_ack=1 and no pending flush: capture rom_data->instr, pc->instr_pc, go HOLD, instr_valid=1 next cycle (minimum latency 1 cycle from ack).
REQ-019 HOLD: instr, instr_pc, instr_valid SHALL stay stable until transfer.
REQ-020 HOLD with transfer: pc<=pc+1 (16-bit, 16'hFFFF wraps to 16'h0000), go REQ, instr_valid=0 next cycle; peak throughput one instruction per 2 cycles.
REQ-021 Priority of pc update SHALL be reset > jump_valid > increment.
REQ-022 jump_valid in IDLE: pc<=jump_addr, remain IDLE (fetch starts when en=1).
REQ-023 jump_valid in HOLD: pc<=jump_addr, instr_valid=0 next cycle, go REQ; a transfer in that same cycle SHALL still count as completed.
REQ-024 jump_valid in REQ with rom_ack=1 same cycle: data discarded, pc<=jump_addr, stay REQ issuing the new address next cycle.
REQ-025 jump_valid in REQ without rom_ack: rom_req/rom_addr SHALL NOT change; set discard flag, pc_next<=jump_addr; on the subsequent ack discard data and re-request at jump target.
REQ-026 A later jump while discard flag set SHALL overwrite the pending target (last jump wins).
REQ-027 en=0 SHALL only gate IDLE exit; it does not stall REQ/HOLD.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: state IDLE, pc=RESET_PC, discard=0, rom_req=0, rom_addr=RESET_PC, instr=16'h0000, instr_pc=16'h0000, instr_valid=0.
REQ-029 Reset mid-REQ SHALL abandon the outstanding ROM request; any late rom_ack after reset release while in IDLE SHALL be ignored.

Structure
REQ-030 Shared package hack_pkg SHALL hold word_t (16-bit logic typedef), fetch_state_e enum and RESET_PC default constant.
REQ-031 One sub-module pc16 (16-bit register with reset/load/inc priority per REQ-021) SHALL be instantiated; FSM and output register stay in pc16_fetch.

Verification
REQ-032 Reset, en=1, ROM acks same cycle as req with data=addr^16'hA5A5, ready=1 -> instr_pc sequence 0,1,2,3, instr 16'hA5A5,16'hA5A4,...
REQ-033 instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc/instr_valid unchanged, rom_req=0, no pc advance.
REQ-034 Jump to 16'h0100 while REQ waiting (ack delayed 3 cycles) -> rom_addr unchanged until ack, that data never valid, next request rom_addr=16'h0100.
REQ-035 Jump to 16'h0040 in HOLD same cycle as transfer of pc 16'h0007 -> 16'h0007 counted once, next instr_pc=16'h0040.
REQ-036 Jump to 16'hFFFF, fetch two words -> instr_pc 16'hFFFF then 16'h0000.
REQ-037 rst_n asserted mid-REQ -> outputs at reset values same cycle without clk; after release with en=0, rom_req stays 0 despite rom_ack=1.
